cpu_mem_responder: RTL and testbench

//   Memory-side responder for the CPU's fetch/load/store requests. Accepts one request at a time over a

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/cpu_mem_responder_timer.sv | 29 ++
 rtl/cpu_mem_responder.sv | 167 ++++++++++++++++
 tb/tb_cpu_mem_responder.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types, MMIO addresses and address-range helper for the CPU memory responder.
package cpu_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } mem_state_t;

    localparam word_t MMIO_LEDR_ADDR = 16'hA000;
    localparam word_t MMIO_SW_ADDR   = 16'hA010;

    // True when the byte address lies beyond a RAM of 2**aw 16-bit words.
    function automatic logic addr_out_of_range(input word_t addr, input int aw);
        return (32'(addr) >> (aw + 1)) != 32'd0;
    endfunction

endpackage

// File: rtl/cpu_mem_responder_timer.sv
// mem_wait_timer: loadable 4-bit down-counter; done is high while the count is zero.
`default_nettype none

module mem_wait_timer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       done
);

    logic [3:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 4'd0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign done = (r_count == 4'd0);

endmodule

`default_nettype wire

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: single-outstanding CPU memory responder with programmable wait states.
// Optional MMIO LED/switch registers are built when CPU_MEM_MMIO_EN is defined.
`default_nettype none

module cpu_mem_responder
    import cpu_pkg::*;
#(
    parameter int AW          = 11,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic          req_fetch,
    input  logic [15:0]   req_addr,
    input  logic [15:0]   req_wdata,
    output logic          rsp_valid,
    output logic [15:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [15:0]   ram_wdata,
    input  logic [15:0]   ram_rdata
`ifdef CPU_MEM_MMIO_EN
    ,
    output logic [15:0]   ledr,
    input  logic [15:0]   sw
`endif
);

    localparam logic [3:0] c_WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    mem_state_t    r_state;
    logic          r_write;
    logic          r_err;
    logic          r_ram_hit;
    logic          r_mmio_rd;
    logic [AW-1:0] r_word_addr;
    word_t         r_wdata;

    logic  w_accept;
    logic  w_done;
    logic  w_oor;
    logic  w_is_mmio_addr;
    logic  w_mmio_wr;
    logic  w_mmio_rd;
    logic  w_mmio_hit;
    logic  w_err;
    logic  w_ram_hit;
    word_t w_mmio_rdata;

    assign w_accept = req_valid && (r_state == IDLE);
    assign w_oor    = addr_out_of_range(req_addr, AW);

`ifdef CPU_MEM_MMIO_EN
    logic r_mmio_wr;
    assign w_is_mmio_addr = (req_addr == MMIO_LEDR_ADDR) || (req_addr == MMIO_SW_ADDR);
    assign w_mmio_wr      = !req_fetch &&  req_write && (req_addr == MMIO_LEDR_ADDR);
    assign w_mmio_rd      = !req_fetch && !req_write && (req_addr == MMIO_SW_ADDR);
    assign w_mmio_rdata   = sw;
`else
    assign w_is_mmio_addr = 1'b0;
    assign w_mmio_wr      = 1'b0;
    assign w_mmio_rd      = 1'b0;
    assign w_mmio_rdata   = 16'h0000;
`endif

    // Error is decided at accept so the zero-wait path can strobe the RAM on the very next edge.
    assign w_mmio_hit = w_mmio_wr || w_mmio_rd;
    assign w_err      = req_addr[0] || (req_fetch && req_write) ||
                        (w_oor && !w_mmio_hit) || (req_fetch && w_is_mmio_addr);
    assign w_ram_hit  = !w_err && !w_mmio_hit;

    mem_wait_timer u_wait_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (w_accept),
        .load_val (c_WAIT_LOAD),
        .dec      (r_state == WAIT),
        .done     (w_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_write     <= 1'b0;
            r_err       <= 1'b0;
            r_ram_hit   <= 1'b0;
            r_mmio_rd   <= 1'b0;
            r_word_addr <= '0;
            r_wdata     <= 16'h0000;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 16'h0000;
            rsp_err     <= 1'b0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
`ifdef CPU_MEM_MMIO_EN
            r_mmio_wr   <= 1'b0;
            ledr        <= 16'h0000;
`endif
        end else begin
            rsp_valid <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write     <= req_write;
                        r_err       <= w_err;
                        r_ram_hit   <= w_ram_hit;
                        r_mmio_rd   <= w_mmio_rd;
                        r_word_addr <= req_addr[AW:1];
                        r_wdata     <= req_wdata;
`ifdef CPU_MEM_MMIO_EN
                        r_mmio_wr   <= w_mmio_wr;
`endif
                        if (WAIT_STATES == 0) begin
                            r_state <= ACCESS;
                            ram_en  <= w_ram_hit;
                            ram_we  <= w_ram_hit && req_write;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (w_done) begin
                        r_state <= ACCESS;
                        ram_en  <= r_ram_hit;
                        ram_we  <= r_ram_hit && r_write;
                    end
                end
                ACCESS: begin
                    r_state <= RESP;
`ifdef CPU_MEM_MMIO_EN
                    if (r_mmio_wr) begin
                        ledr <= r_wdata;
                    end
`endif
                end
                RESP: begin
                    r_state   <= IDLE;
                    rsp_valid <= 1'b1;
                    rsp_err   <= r_err;
                    if (r_err || r_write) begin
                        rsp_rdata <= 16'h0000;
                    end else if (r_mmio_rd) begin
                        rsp_rdata <= w_mmio_rdata;
                    end else begin
                        rsp_rdata <= ram_rdata;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign ram_addr  = r_word_addr;
    assign ram_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
// Testbench for cpu_mem_responder: two instances (0 and 3 wait states) with a scoreboard of expected responses.
`timescale 1ns/1ps
`default_nettype none

module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic        req_fetch [2];
    logic [15:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [15:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        ram_en    [2];
    logic        ram_we    [2];
    logic [10:0] ram_addr  [2];
    logic [15:0] ram_wdata [2];
    logic [15:0] ram_rdata [2];
    logic [15:0] mem [2][2048];
    int          en_count [2];
`ifdef CPU_MEM_MMIO_EN
    logic [15:0] ledr [2];
    logic [15:0] sw   [2];
`endif

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cpu_mem_responder #(
            .AW          (11),
            .WAIT_STATES ((g == 0) ? 0 : 3)
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_fetch (req_fetch[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .ram_en    (ram_en[g]),
            .ram_we    (ram_we[g]),
            .ram_addr  (ram_addr[g]),
            .ram_wdata (ram_wdata[g]),
            .ram_rdata (ram_rdata[g])
`ifdef CPU_MEM_MMIO_EN
            ,
            .ledr      (ledr[g]),
            .sw        (sw[g])
`endif
        );
    end

    // Synchronous single-port RAM per instance, 1-cycle read latency.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ram_en[d]) begin
                en_count[d] <= en_count[d] + 1;
                if (ram_we[d]) mem[d][ram_addr[d]] <= ram_wdata[d];
                else           ram_rdata[d] <= mem[d][ram_addr[d]];
            end
        end
    end

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Issue one request, expect the response WAIT_STATES+2 cycles after the accept edge.
    task automatic do_req(input int d, input logic wr, input logic fe, input logic [15:0] a,
                          input logic [15:0] wd, input logic [15:0] er, input logic ee);
        int   lat;
        logic got;
        logic ready_low;
        exp_t e;
        @(negedge clk);
        req_valid[d] = 1'b1; req_write[d] = wr; req_fetch[d] = fe;
        req_addr[d]  = a;    req_wdata[d] = wd;
        sb.push_back('{er, ee});
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        got = 1'b0; lat = 0; ready_low = !req_ready[d];
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (rsp_valid[d]) begin got = 1'b1; lat = c; break; end
            if (req_ready[d]) ready_low = 1'b0;
        end
        e = sb.pop_front();
        n_vec++;
        if (!got) begin
            n_bad++;
            $display("FAIL timeout dut%0d addr=%h: no rsp_valid within 30 cycles", d, a);
        end else begin
            if (lat != ws(d) + 2) begin
                n_bad++;
                $display("FAIL latency dut%0d addr=%h: got %0d want %0d", d, a, lat, ws(d) + 2);
            end
            n_vec++;
            if (rsp_rdata[d] !== e.rdata) begin
                n_bad++;
                $display("FAIL rdata dut%0d addr=%h: got %h want %h", d, a, rsp_rdata[d], e.rdata);
            end
            n_vec++;
            if (rsp_err[d] !== e.err) begin
                n_bad++;
                $display("FAIL err dut%0d addr=%h: got %b want %b", d, a, rsp_err[d], e.err);
            end
            n_vec++;
            if (ready_low !== 1'b1 || req_ready[d] !== 1'b1) begin
                n_bad++;
                $display("FAIL ready dut%0d addr=%h: busy_low=%b ready_at_rsp=%b want 1/1",
                         d, a, ready_low, req_ready[d]);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 16'h0 ||
                rsp_err[d] !== 1'b0 || ram_en[d] !== 1'b0 || ram_we[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset dut%0d: ready=%b valid=%b rdata=%h err=%b en=%b we=%b want 1/0/0000/0/0/0",
                         d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d], ram_en[d], ram_we[d]);
            end
`ifdef CPU_MEM_MMIO_EN
            n_vec++;
            if (ledr[d] !== 16'h0) begin
                n_bad++;
                $display("FAIL reset_ledr dut%0d: got %h want 0000", d, ledr[d]);
            end
`endif
        end
    endtask

    task automatic test_basic_rw();
        do_req(0, 1'b1, 1'b0, 16'h0010, 16'h1234, 16'h0000, 1'b0);
        do_req(0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0);
        do_req(0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h1234, 1'b0);
        do_req(0, 1'b1, 1'b0, 16'h0FFE, 16'hA5A5, 16'h0000, 1'b0);
        do_req(0, 1'b0, 1'b0, 16'h0FFE, 16'h0000, 16'hA5A5, 1'b0);
        n_vec++;
        if (mem[0][11'h008] !== 16'h1234) begin
            n_bad++;
            $display("FAIL ram_word8: got %h want 1234", mem[0][11'h008]);
        end
    endtask

    task automatic test_wait_states();
        do_req(1, 1'b1, 1'b0, 16'h0020, 16'hBEEF, 16'h0000, 1'b0);
        do_req(1, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'hBEEF, 1'b0);
    endtask

    task automatic test_errors();
        int en0;
        do_req(0, 1'b1, 1'b0, 16'h0000, 16'h5555, 16'h0000, 1'b0);
        en0 = en_count[0];
        do_req(0, 1'b0, 1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1);
        do_req(0, 1'b1, 1'b0, 16'h0011, 16'hFFFF, 16'h0000, 1'b1);
        do_req(0, 1'b1, 1'b1, 16'h0000, 16'hDEAD, 16'h0000, 1'b1);
        do_req(0, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h0000, 1'b1);
        do_req(0, 1'b1, 1'b0, 16'hA000, 16'h00FF, 16'h0000, 1'b1);
        n_vec++;
        if (en_count[0] !== en0) begin
            n_bad++;
            $display("FAIL err_ram_en: ram_en strobes=%0d want 0", en_count[0] - en0);
        end
        n_vec++;
        if (mem[0][11'h008] !== 16'h1234 || mem[0][11'h000] !== 16'h5555) begin
            n_bad++;
            $display("FAIL err_ram_kept: word8=%h word0=%h want 1234/5555", mem[0][11'h008], mem[0][11'h000]);
        end
    endtask

    task automatic test_reset_mid_op();
        int   en1;
        logic saw_rsp;
        do_req(1, 1'b1, 1'b0, 16'h0030, 16'h7777, 16'h0000, 1'b0);
        en1 = en_count[1];
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_fetch[1] = 1'b0;
        req_addr[1]  = 16'h0030; req_wdata[1] = 16'h9999;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: ready=%b valid=%b want 1/0", req_ready[1], rsp_valid[1]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        saw_rsp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (rsp_valid[1]) saw_rsp = 1'b1;
        end
        n_vec++;
        if (saw_rsp !== 1'b0 || en_count[1] !== en1 || mem[1][11'h018] !== 16'h7777) begin
            n_bad++;
            $display("FAIL reset_drop: rsp_seen=%b strobes=%0d word18=%h want 0/0/7777",
                     saw_rsp, en_count[1] - en1, mem[1][11'h018]);
        end
        n_vec++;
        if (req_ready[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", req_ready[1]);
        end
        do_req(1, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'h7777, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [3];
        logic [15:0] datas [3];
        int   issued, done_n, cyc, last_acc;
        logic acc;
        exp_t e;
        addrs = '{16'h0040, 16'h0042, 16'h0FFE};
        datas = '{16'h1111, 16'h2222, 16'h3333};
        for (int k = 0; k < 3; k++) do_req(1, 1'b1, 1'b0, addrs[k], datas[k], 16'h0000, 1'b0);
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_fetch[1] = 1'b0;
        req_addr[1]  = addrs[0];
        issued = 0; done_n = 0; cyc = 0; last_acc = 0;
        while (done_n < 3 && cyc < 80) begin
            acc = req_ready[1] && req_valid[1];
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (issued > 0) begin
                    n_vec++;
                    if (cyc - last_acc != 6) begin
                        n_bad++;
                        $display("FAIL b2b_spacing: got %0d want 6", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                sb.push_back('{datas[issued], 1'b0});
                issued++;
                if (issued < 3) req_addr[1] = addrs[issued];
                else            req_valid[1] = 1'b0;
            end
            if (rsp_valid[1]) begin
                e = sb.pop_front();
                n_vec++;
                if (rsp_rdata[1] !== e.rdata || rsp_err[1] !== e.err) begin
                    n_bad++;
                    $display("FAIL b2b_data #%0d: got %h/%b want %h/%b",
                             done_n, rsp_rdata[1], rsp_err[1], e.rdata, e.err);
                end
                done_n++;
            end
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        if (done_n < 3) begin
            n_vec++;
            n_bad++;
            $display("FAIL b2b_timeout: %0d of 3 responses", done_n);
            sb.delete();
        end
    endtask

`ifdef CPU_MEM_MMIO_EN
    task automatic test_mmio();
        int en0;
        en0 = en_count[0];
        do_req(0, 1'b1, 1'b0, 16'hA000, 16'h00FF, 16'h0000, 1'b0);
        n_vec++;
        if (ledr[0] !== 16'h00FF) begin
            n_bad++;
            $display("FAIL mmio_ledr: got %h want 00ff", ledr[0]);
        end
        sw[0] = 16'h0155;
        do_req(0, 1'b0, 1'b0, 16'hA010, 16'h0000, 16'h0155, 1'b0);
        do_req(0, 1'b0, 1'b1, 16'hA010, 16'h0000, 16'h0000, 1'b1);
        n_vec++;
        if (en_count[0] !== en0) begin
            n_bad++;
            $display("FAIL mmio_ram_en: strobes=%0d want 0", en_count[0] - en0);
        end
    endtask
`endif

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_fetch[d] = 1'b0;
            req_addr[d]  = 16'h0; req_wdata[d] = 16'h0;
`ifdef CPU_MEM_MMIO_EN
            sw[d] = 16'h0;
`endif
        end
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        test_basic_rw();
        test_wait_states();
        test_errors();
        test_reset_mid_op();
        test_back_to_back();
`ifdef CPU_MEM_MMIO_EN
        test_mmio();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
